fft_frame_reader: RTL and testbench
===================================

FFT_FRAME_READER -- requirements
Module: fft_frame_reader

Interface
REQ-001 SHALL have parameter OW, default 18: width of each signed real/imag component of the input bin.
REQ-002 SHALL have parameter FFT_SIZE, default 256: FFT length, power of two; NBINS = FFT_SIZE/2 bins retained per frame.
REQ-003 SHALL have port i_clk input 1: clock, all logic on rising edge.
REQ-004 SHALL have port i_reset input 1: reset, synchronous, active-high.
REQ-005 SHALL have port i_ce input 1: one FFT bin presented per cycle i_ce=1.
REQ-006 SHALL have port i_result input 2*OW: {real[2*OW-1:OW], imag[OW-1:0]}, two's complement, natural bin order.
REQ-007 SHALL have port i_sync input 1: high together with i_ce on bin 0 of each frame.
REQ-008 SHALL have port o_valid output 1: o_power/o_bin/o_last valid.
REQ-009 SHALL have port i_ready input 1: downstream accepts when o_valid and i_ready both high.
REQ-010 SHALL have port o_power output 2*OW: unsigned bin power re^2+im^2.
REQ-011 SHALL have port o_bin output $clog2(NBINS): bin index of o_power.
REQ-012 SHALL have port o_last output 1: high with bin NBINS-1.
REQ-013 SHALL have port o_drop_cnt output 8: saturating dropped-frame count (see Configuration).

Function
REQ-014 Power SHALL be computed full-precision: re*re + im*im fits 2*OW bits unsigned (max 2^(2*OW-1)), no saturation or truncation.
REQ-015 Power path SHALL be 2 registered stages (products, then sum), advancing every cycle; bin index and write strobe pipelined alongside; write into bank occurs 2 cycles after the accepting i_ce.
REQ-016 Capture FSM states: WAIT_SYNC, CAPTURE, SKIP; reset to WAIT_SYNC.
REQ-017 WAIT_SYNC: i_ce without i_sync ignored; i_ce&i_sync -> store bin 0, go CAPTURE, bin counter = 1.
REQ-018 CAPTURE: each i_ce stores bin at counter, counter++; on storing bin NBINS-1 -> SKIP and frame complete.
REQ-019 SKIP: bins NBINS..FFT_SIZE-1 discarded; i_ce&i_sync -> store bin 0, go CAPTURE.
REQ-020 i_sync in CAPTURE (early sync) SHALL discard the partial frame, store bin 0 into the same write bank, restart counter at 1; not counted as a drop.
REQ-021 Two banks of NBINS entries (ping-pong): capture writes write bank, reader drains read bank.
REQ-022 On frame complete (after final write lands): if reader idle, banks swap and reader starts; else frame dropped, write bank reused, o_drop_cnt incremented.
REQ-023 Read FSM states: IDLE, STREAM; STREAM drains bins 0..NBINS-1 in order, o_last on bin NBINS-1, returns to IDLE after its acceptance.
REQ-024 First o_valid SHALL assert no later than 2 cycles after swap; sustained throughput one bin/cycle while i_ready=1.
REQ-025 While o_valid=1 and i_ready=0, o_power/o_bin/o_last SHALL hold stable; o_valid SHALL not drop without acceptance.
REQ-026 Frame complete on the same cycle the reader accepts its o_last SHALL swap (not drop).
REQ-027 Bank read and bank write SHALL never target the same bank.

Reset
REQ-028 i_reset SHALL override all other inputs, including mid-frame and mid-stream.
REQ-029 Reset values: o_valid=0, o_power=0, o_bin=0, o_last=0, o_drop_cnt=0, both FSMs to initial state, pipeline strobes cleared; bank contents need not reset.
REQ-030 Cycle after reset release, block SHALL behave as freshly started (WAIT_SYNC, IDLE).

Configuration
REQ-031 Macro FFT_FRAME_READER_DROP_CNT_EN: defined -> o_drop_cnt counts drops per REQ-022, saturating at 255; undefined -> counter logic omitted, o_drop_cnt tied to 0.

Verification
REQ-032 Reset, then frame with every bin re=3, im=-4 and i_sync on bin 0, i_ready=1 -> 128 outputs o_power=25, o_bin 0..127, o_last only on bin 127.
REQ-033 Bin k = {re=k, im=0}, i_ready toggling 1/0 each cycle -> o_power=k^2 in order, outputs stable while stalled, no bin lost or duplicated.
REQ-034 Bins re=im=-2^17 (OW=18) -> o_power=2^35 exactly.
REQ-035 i_ready=0 held, three back-to-back frames -> frame 1 held in read bank, frame 2 completes (swap impossible, reader busy) dropped, frame 3 dropped; o_drop_cnt=2 with macro, 0 without; releasing i_ready streams frame 1 only.
REQ-036 i_sync reasserted at bin 50 of a frame -> no output for partial frame; next full 128 bins stream correctly; o_drop_cnt unchanged.
REQ-037 i_reset pulsed mid-stream at bin 60 -> next cycle o_valid=0, o_drop_cnt=0; data before a subsequent i_sync ignored.

Source files
------------

// File: rtl/fft_frame_reader.sv
// Captures the first half of each FFT frame as bin power into ping-pong banks and streams it out with valid/ready.
// Optional macro FFT_FRAME_READER_DROP_CNT_EN enables the saturating dropped-frame counter on o_drop_cnt.
module fft_frame_reader #(
  parameter int OW       = 18,
  parameter int FFT_SIZE = 256
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_ce,
  input  logic [2*OW-1:0]                 i_result,
  input  logic                            i_sync,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [2*OW-1:0]                 o_power,
  output logic [$clog2(FFT_SIZE/2)-1:0]   o_bin,
  output logic                            o_last,
  output logic [7:0]                      o_drop_cnt
);
  localparam int NBINS = FFT_SIZE / 2;
  localparam int AW    = $clog2(NBINS);

  typedef enum logic [1:0] {WAIT_SYNC, CAPTURE, SKIP} cap_state_t;
  typedef enum logic {IDLE, STREAM} rd_state_t;

  cap_state_t        cap_state_reg;
  logic [AW-1:0]     cap_cnt_reg;
  logic              cap_we;
  logic [AW-1:0]     cap_addr;
  logic              cap_last;

  logic              s1_we_reg, s1_last_reg;
  logic [AW-1:0]     s1_addr_reg;
  logic [2*OW-1:0]   s1_pr_reg, s1_pi_reg;
  logic              s2_we_reg, s2_last_reg;
  logic [AW-1:0]     s2_addr_reg;
  logic [2*OW-1:0]   s2_pow_reg;

  rd_state_t         rd_state_reg;
  logic [AW-1:0]     rd_cnt_reg;
  logic              wr_bank_reg;
  logic              frame_done, rdr_free, swap;

  logic [2*OW-1:0]   bank_mem [0:2*NBINS-1];

  logic signed [2*OW-1:0] re_ext, im_ext;
  assign re_ext = {{OW{i_result[2*OW-1]}}, i_result[2*OW-1:OW]};
  assign im_ext = {{OW{i_result[OW-1]}}, i_result[OW-1:0]};

  // A sync always restarts the frame at bin 0, whatever the capture state.
  always_comb begin
    cap_we   = 1'b0;
    cap_addr = cap_cnt_reg;
    cap_last = 1'b0;
    if (i_ce) begin
      if (i_sync) begin
        cap_we   = 1'b1;
        cap_addr = '0;
      end else if (cap_state_reg == CAPTURE) begin
        cap_we   = 1'b1;
        cap_last = (cap_cnt_reg == AW'(NBINS - 1));
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cap_state_reg <= WAIT_SYNC;
      cap_cnt_reg   <= '0;
      s1_we_reg     <= 1'b0;
      s1_last_reg   <= 1'b0;
      s1_addr_reg   <= '0;
      s2_we_reg     <= 1'b0;
      s2_last_reg   <= 1'b0;
      s2_addr_reg   <= '0;
    end else begin
      s1_we_reg   <= cap_we;
      s1_last_reg <= cap_last;
      s1_addr_reg <= cap_addr;
      s2_we_reg   <= s1_we_reg;
      s2_last_reg <= s1_last_reg;
      s2_addr_reg <= s1_addr_reg;
      if (cap_we) begin
        if (cap_last) begin
          cap_state_reg <= SKIP;
        end else begin
          cap_state_reg <= CAPTURE;
          cap_cnt_reg   <= cap_addr + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    s1_pr_reg  <= re_ext * re_ext;
    s1_pi_reg  <= im_ext * im_ext;
    s2_pow_reg <= s1_pr_reg + s1_pi_reg;
  end

  always_ff @(posedge i_clk) begin
    if (s2_we_reg)
      bank_mem[{wr_bank_reg, s2_addr_reg}] <= s2_pow_reg;
  end

  // The reader is free if idle or handing off its final bin this very cycle.
  assign frame_done = s2_we_reg & s2_last_reg;
  assign rdr_free   = (rd_state_reg == IDLE) | (o_valid & o_last & i_ready);
  assign swap       = frame_done & rdr_free;

  // The output register doubles as the bank read register; it only advances when the slot is empty or taken.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_state_reg <= IDLE;
      rd_cnt_reg   <= '0;
      wr_bank_reg  <= 1'b0;
      o_valid      <= 1'b0;
      o_power      <= '0;
      o_bin        <= '0;
      o_last       <= 1'b0;
    end else if (swap) begin
      wr_bank_reg  <= ~wr_bank_reg;
      rd_state_reg <= STREAM;
      rd_cnt_reg   <= '0;
      o_valid      <= 1'b0;
      o_last       <= 1'b0;
    end else if (rd_state_reg == STREAM && (!o_valid || i_ready)) begin
      if (o_valid && o_last) begin
        rd_state_reg <= IDLE;
        o_valid      <= 1'b0;
        o_last       <= 1'b0;
      end else begin
        o_valid    <= 1'b1;
        o_power    <= bank_mem[{~wr_bank_reg, rd_cnt_reg}];
        o_bin      <= rd_cnt_reg;
        o_last     <= (rd_cnt_reg == AW'(NBINS - 1));
        rd_cnt_reg <= rd_cnt_reg + 1'b1;
      end
    end
  end

`ifdef FFT_FRAME_READER_DROP_CNT_EN
  logic [7:0] drop_cnt_reg;
  always_ff @(posedge i_clk) begin
    if (i_reset)
      drop_cnt_reg <= 8'd0;
    else if (frame_done && !rdr_free && drop_cnt_reg != 8'hFF)
      drop_cnt_reg <= drop_cnt_reg + 8'd1;
  end
  assign o_drop_cnt = drop_cnt_reg;
`else
  assign o_drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_fft_frame_reader.sv
// Directed bench for fft_frame_reader: table of constant-bin frames plus hand sequences for stalls, drops, early sync and reset.
module tb_fft_frame_reader;
  localparam int OW       = 18;
  localparam int FFT_SIZE = 256;
  localparam int NBINS    = FFT_SIZE / 2;

  typedef struct {
    logic signed [OW-1:0] re;
    logic signed [OW-1:0] im;
    logic [2*OW-1:0]      power;
  } vec_t;

  typedef struct {
    logic [2*OW-1:0] power;
    logic [6:0]      bin;
    logic            last;
  } exp_t;

  logic            i_clk = 1'b0;
  logic            i_reset = 1'b1;
  logic            i_ce = 1'b0;
  logic            i_sync = 1'b0;
  logic            i_ready = 1'b1;
  logic [2*OW-1:0] i_result = '0;
  logic            o_valid;
  logic [2*OW-1:0] o_power;
  logic [6:0]      o_bin;
  logic            o_last;
  logic [7:0]      o_drop_cnt;

  fft_frame_reader #(.OW(OW), .FFT_SIZE(FFT_SIZE)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_ce       (i_ce),
    .i_result   (i_result),
    .i_sync     (i_sync),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_power    (o_power),
    .o_bin      (o_bin),
    .o_last     (o_last),
    .o_drop_cnt (o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  int              checks = 0;
  int              errors = 0;
  int              ready_mode = 0;   // 0: always ready, 1: toggle, 2: held low
  exp_t            expq[$];
  logic            prev_stall = 1'b0;
  logic [2*OW-1:0] prev_power;
  logic [6:0]      prev_bin;
  logic            prev_last;
  vec_t            tbl[6];
  int              exp_drop;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (i_reset) begin
      prev_stall = 1'b0;
      return;
    end
    if (prev_stall) begin
      checks++;
      if (!o_valid || o_power != prev_power || o_bin != prev_bin || o_last != prev_last) begin
        errors++;
        $display("FAIL stall_hold actual valid=%0d bin=%0d power=%0d required valid=1 bin=%0d power=%0d",
                 o_valid, o_bin, o_power, prev_bin, prev_power);
      end
    end
    if (o_valid && i_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual bin=%0d power=%0d required no output", o_bin, o_power);
      end else begin
        e = expq.pop_front();
        check($sformatf("power[bin %0d]", e.bin), o_power, e.power);
        check($sformatf("bin[bin %0d]", e.bin), o_bin, e.bin);
        check($sformatf("last[bin %0d]", e.bin), o_last, e.last);
      end
    end
    prev_stall = o_valid && !i_ready;
    prev_power = o_power;
    prev_bin   = o_bin;
    prev_last  = o_last;
  endtask

  task automatic cycle();
    @(posedge i_clk);
    #1;
    case (ready_mode)
      0:       i_ready = 1'b1;
      1:       i_ready = ~i_ready;
      default: i_ready = 1'b0;
    endcase
    @(negedge i_clk);
    monitor();
  endtask

  task automatic send_bin(input logic sync, input logic signed [OW-1:0] re, input logic signed [OW-1:0] im);
    i_ce     = 1'b1;
    i_sync   = sync;
    i_result = {re, im};
    cycle();
  endtask

  task automatic idle(input int n);
    i_ce   = 1'b0;
    i_sync = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic send_frame(input logic signed [OW-1:0] re, input logic signed [OW-1:0] im, input bit ramp);
    for (int k = 0; k < FFT_SIZE; k++)
      send_bin(k == 0, ramp ? OW'(k) : re, im);
    i_ce   = 1'b0;
    i_sync = 1'b0;
  endtask

  task automatic push_frame(input logic [2*OW-1:0] power, input bit ramp);
    exp_t e;
    for (int k = 0; k < NBINS; k++) begin
      e.power = ramp ? (2*OW)'(k * k) : power;
      e.bin   = 7'(k);
      e.last  = (k == NBINS - 1);
      expq.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((expq.size() != 0 || o_valid) && n < 3000) begin
      cycle();
      n++;
    end
    checks++;
    if (expq.size() != 0 || o_valid) begin
      errors++;
      $display("FAIL drain_timeout actual pending=%0d required pending=0", expq.size());
    end
  endtask

  initial begin
    int found;
    tbl[0] = '{re: 18'sd3,       im: -18'sd4,      power: 36'd25};
    tbl[1] = '{re: -18'sd131072, im: -18'sd131072, power: 36'd34359738368};
    tbl[2] = '{re: 18'sd0,       im: 18'sd0,       power: 36'd0};
    tbl[3] = '{re: 18'sd131071,  im: -18'sd131072, power: 36'd34359476225};
    tbl[4] = '{re: -18'sd1,      im: 18'sd1,       power: 36'd2};
    tbl[5] = '{re: 18'sd100,     im: -18'sd200,    power: 36'd50000};
`ifdef FFT_FRAME_READER_DROP_CNT_EN
    exp_drop = 2;
`else
    exp_drop = 0;
`endif

    // Reset state
    i_reset = 1'b1;
    repeat (3) cycle();
    check("reset_valid", o_valid, 0);
    check("reset_power", o_power, 0);
    check("reset_bin", o_bin, 0);
    check("reset_last", o_last, 0);
    check("reset_drop", o_drop_cnt, 0);
    i_reset = 1'b0;
    idle(2);
    check("idle_valid", o_valid, 0);

    // Table of constant-value frames, streamed with i_ready high
    ready_mode = 0;
    for (int i = 0; i < 6; i++) begin
      push_frame(tbl[i].power, 1'b0);
      send_frame(tbl[i].re, tbl[i].im, 1'b0);
      $display("frame %0d re=%0d im=%0d power=%0d sent, errors so far %0d", i, tbl[i].re, tbl[i].im, tbl[i].power, errors);
    end
    drain();
    check("drop_after_table", o_drop_cnt, 0);

    // Ramp frame with i_ready toggling every cycle
    ready_mode = 1;
    push_frame('0, 1'b1);
    send_frame('0, '0, 1'b1);
    drain();
    ready_mode = 0;
    $display("ramp frame with toggling ready done, errors so far %0d", errors);

    // Three back-to-back frames with the reader stalled: frames 2 and 3 are dropped
    ready_mode = 2;
    push_frame(36'd1, 1'b0);
    send_frame(18'sd1, 18'sd0, 1'b0);
    send_frame(18'sd2, 18'sd0, 1'b0);
    send_frame(18'sd3, 18'sd0, 1'b0);
    check("stalled_valid", o_valid, 1);
    check("stalled_bin", o_bin, 0);
    check("stalled_power", o_power, 1);
    check("drop_cnt_after_3", o_drop_cnt, exp_drop);
    ready_mode = 0;
    drain();
    idle(10);
    $display("stalled three-frame drop sequence done, errors so far %0d", errors);

    // Early sync at bin 50 discards the partial frame
    push_frame(36'd36, 1'b0);
    for (int k = 0; k < 50; k++)
      send_bin(k == 0, 18'sd5, 18'sd0);
    send_frame(18'sd6, 18'sd0, 1'b0);
    drain();
    check("drop_after_early_sync", o_drop_cnt, exp_drop);
    $display("early sync sequence done, errors so far %0d", errors);

    // Reset mid-stream at bin 60
    push_frame(36'd49, 1'b0);
    for (int k = 0; k < NBINS; k++)
      send_bin(k == 0, 18'sd7, 18'sd0);
    i_ce = 1'b0;
    found = 0;
    for (int n = 0; n < 200; n++) begin
      if (o_valid && i_ready && o_bin == 7'd60) begin
        found = 1;
        break;
      end
      cycle();
    end
    check("reached_bin60", found, 1);
    i_reset = 1'b1;
    expq.delete();
    cycle();
    check("midreset_valid", o_valid, 0);
    check("midreset_last", o_last, 0);
    check("midreset_drop", o_drop_cnt, 0);
    i_reset = 1'b0;
    for (int k = 0; k < 140; k++)
      send_bin(1'b0, 18'sd9, 18'sd0);
    idle(10);
    check("no_output_before_sync", o_valid, 0);
    push_frame(36'd64, 1'b0);
    send_frame(18'sd8, 18'sd0, 1'b0);
    drain();
    $display("mid-stream reset sequence done, errors so far %0d", errors);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
